// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath mux/ALU encodings, op classes, condition codes and the ALU command decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // writes: result goes back to Rd; arith: C and V are meaningful for flag update
    typedef struct packed {
        logic [2:0] ctrl;
        logic       writes;
        logic       arith;
    } alu_dec_t;

    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{ctrl: ALU_ADD, writes: 1'b0, arith: 1'b0};
        case (cmd)
            4'b0100: d = '{ctrl: ALU_ADD, writes: 1'b1, arith: 1'b1};
            4'b0010: d = '{ctrl: ALU_SUB, writes: 1'b1, arith: 1'b1};
            4'b0000: d = '{ctrl: ALU_AND, writes: 1'b1, arith: 1'b0};
            4'b1100: d = '{ctrl: ALU_ORR, writes: 1'b1, arith: 1'b0};
            4'b1010: d = '{ctrl: ALU_SUB, writes: 1'b0, arith: 1'b1};
            4'b1101: d = '{ctrl: ALU_MOV, writes: 1'b1, arith: 1'b0};
            default: d = '{ctrl: ALU_ADD, writes: 1'b0, arith: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath bundle: decoded IR fields, ALU flags and memory
// handshake in one direction, datapath enables and mux selects in the other.
interface mc_control_unit_if;
    import mc_ctrl_pkg::*;

    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;

    logic       PCWrite;
    logic       IRWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       ByteMem;
    logic       RegWrite;
    logic [1:0] RegSrc;
    logic [1:0] ImmSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ResultSrc;

    modport master (
        input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
        output PCWrite, IRWrite, AdrSrc, MemWrite, ByteMem, RegWrite,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc
    );

    modport slave (
        output Cond, Op, Funct, Rd, ALUFlags, MemReady,
        input  PCWrite, IRWrite, AdrSrc, MemWrite, ByteMem, RegWrite,
               RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc
    );
endinterface

// File: rtl/mc_control_unit_cond_check.sv
// NZCV flags register plus condition-code evaluation; CondEx always reflects
// the flags as they stand now, so flags set by this instruction apply after its EXECUTE.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_we_nz,
    input  logic       flag_we_cv,
    output logic       cond_ex
);
    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_we_nz) flags[3:2] <= alu_flags[3:2];
            if (flag_we_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: sequences fetch/decode/execute over a shared memory
// port and ALU, stalling on MemReady and gating architectural writes with CondEx.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mc_control_unit_if.master bus
);
    state_t     state, state_next;
    alu_dec_t   dec;
    logic       cond_ex;
    logic       irw, fetch_pc, memw, regw, branch;
    logic       flag_we_nz, flag_we_cv;
    logic       adr_src, byte_mem, alu_src_a;
    logic [1:0] reg_src, imm_src, alu_src_b, result_src;
    logic [2:0] alu_control;

    assign dec = alu_decode(bus.Funct[4:1]);

    cond_check u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (bus.Cond),
        .alu_flags  (bus.ALUFlags),
        .flag_we_nz (flag_we_nz),
        .flag_we_cv (flag_we_cv),
        .cond_ex    (cond_ex)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        irw         = 1'b0;
        fetch_pc    = 1'b0;
        memw        = 1'b0;
        regw        = 1'b0;
        branch      = 1'b0;
        flag_we_nz  = 1'b0;
        flag_we_cv  = 1'b0;
        adr_src     = 1'b0;
        byte_mem    = 1'b0;
        alu_src_a   = 1'b0;
        reg_src     = 2'b00;
        imm_src     = IMM_8;
        alu_src_b   = SRCB_REG;
        alu_control = ALU_ADD;
        result_src  = RES_ALUOUT;

        case (state)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (bus.MemReady) begin
                    irw        = 1'b1;
                    fetch_pc   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            // R15 reads as PC+8 because the ALU adds another 4 to the already-advanced PC
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                case (bus.Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = SRCB_EXT;
                imm_src    = IMM_12;
                byte_mem   = bus.Funct[2];
                state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src  = 1'b1;
                byte_mem = bus.Funct[2];
                if (bus.MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                regw       = 1'b1;
                byte_mem   = bus.Funct[2];
                state_next = S_FETCH;
            end
            // write strobe is held for the whole stall but only commits with MemReady
            S_MEMWR: begin
                adr_src  = 1'b1;
                reg_src  = 2'b10;
                memw     = 1'b1;
                byte_mem = bus.Funct[2];
                if (bus.MemReady) state_next = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_b   = (state == S_EXECUTEI) ? SRCB_EXT : SRCB_REG;
                imm_src     = IMM_8;
                alu_control = dec.ctrl;
                flag_we_nz  = bus.Funct[0] & cond_ex;
                flag_we_cv  = bus.Funct[0] & cond_ex & dec.arith;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                regw       = dec.writes;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b  = SRCB_EXT;
                imm_src    = IMM_24;
                result_src = RES_ALU;
                reg_src    = 2'b01;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // architectural writes are suppressed outright while reset is asserted
    assign bus.PCWrite    = ~reset & (fetch_pc | (branch & cond_ex) |
                                      (regw & (bus.Rd == 4'd15) & cond_ex));
    assign bus.IRWrite    = ~reset & irw;
    assign bus.MemWrite   = ~reset & memw & cond_ex & bus.MemReady;
    assign bus.RegWrite   = ~reset & regw & cond_ex;
    assign bus.AdrSrc     = adr_src;
    assign bus.ByteMem    = byte_mem;
    assign bus.RegSrc     = reg_src;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ALUControl = alu_control;
    assign bus.ResultSrc  = result_src;
endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: an instruction-level model expands each instruction
// into its expected per-cycle control words, compared against the DUT every cycle.
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mc_control_unit_if bus();

    mc_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        mr;
        logic [17:0] cw;
    } rec_t;

    rec_t       q[$];
    logic [3:0] mflags;
    logic [3:0] pend_flags;
    int         vectors = 0;
    int         errors = 0;

    function automatic logic [17:0] cw(input logic pcw, input logic irw, input logic adr,
                                       input logic memw, input logic bytem, input logic regw,
                                       input logic [1:0] regsrc, input logic [1:0] imm,
                                       input logic srca, input logic [1:0] srcb,
                                       input logic [2:0] aluc, input logic [1:0] res);
        return {pcw, irw, adr, memw, bytem, regw, regsrc, imm, srca, srcb, aluc, res};
    endfunction

    function automatic rec_t mk(input logic mr, input logic [17:0] w);
        rec_t r;
        r.mr = mr;
        r.cw = w;
        return r;
    endfunction

    // ARM condition codes come in pairs: odd code is the negation of the even one
    function automatic logic holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        {n, z, cy, v} = f;
        if (c == 4'b1110) return 1'b1;
        if (c == 4'b1111) return 1'b0;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cy;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cy && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic alu_tab(input logic [3:0] cmd, output logic [2:0] ac,
                           output logic wr, output logic ar);
        ac = 3'b000; wr = 1'b0; ar = 1'b0;
        case (cmd)
            4'b0100: begin ac = 3'b000; wr = 1'b1; ar = 1'b1; end
            4'b0010: begin ac = 3'b001; wr = 1'b1; ar = 1'b1; end
            4'b0000: begin ac = 3'b010; wr = 1'b1; end
            4'b1100: begin ac = 3'b011; wr = 1'b1; end
            4'b1010: begin ac = 3'b001; ar = 1'b1; end
            4'b1101: begin ac = 3'b100; wr = 1'b1; end
            default: ;
        endcase
    endtask

    task automatic build(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] aluf,
                         input int fstall, input int mstall);
        logic cx, b, r15, wr, ar, w;
        logic [2:0] ac;
        cx = holds(cond, mflags);
        b = (op == 2'b01) && funct[2];
        r15 = (rd == 4'd15);
        q.delete();
        pend_flags = mflags;
        for (int i = 0; i < fstall; i++)
            q.push_back(mk(1'b0, cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b000,2'b10)));
        q.push_back(mk(1'b1, cw(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b000,2'b10)));
        q.push_back(mk(1'b1, cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,3'b000,2'b10)));
        if (op == 2'b10) begin
            q.push_back(mk(1'b1, cw(cx,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b10,1'b0,2'b01,3'b000,2'b10)));
        end else if (op == 2'b01) begin
            q.push_back(mk(1'b1, cw(1'b0,1'b0,1'b0,1'b0,b,1'b0,2'b00,2'b01,1'b0,2'b01,3'b000,2'b00)));
            if (funct[0]) begin
                for (int i = 0; i < mstall; i++)
                    q.push_back(mk(1'b0, cw(1'b0,1'b0,1'b1,1'b0,b,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00)));
                q.push_back(mk(1'b1, cw(1'b0,1'b0,1'b1,1'b0,b,1'b0,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00)));
                q.push_back(mk(1'b1, cw(cx && r15,1'b0,1'b0,1'b0,b,cx,2'b00,2'b00,1'b0,2'b00,3'b000,2'b01)));
            end else begin
                for (int i = 0; i < mstall; i++)
                    q.push_back(mk(1'b0, cw(1'b0,1'b0,1'b1,1'b0,b,1'b0,2'b10,2'b00,1'b0,2'b00,3'b000,2'b00)));
                q.push_back(mk(1'b1, cw(1'b0,1'b0,1'b1,cx,b,1'b0,2'b10,2'b00,1'b0,2'b00,3'b000,2'b00)));
            end
        end else if (op == 2'b00) begin
            alu_tab(funct[4:1], ac, wr, ar);
            q.push_back(mk(1'b1, cw(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,
                                    funct[5] ? 2'b01 : 2'b00, ac, 2'b00)));
            w = wr && cx;
            q.push_back(mk(1'b1, cw(w && r15,1'b0,1'b0,1'b0,1'b0,w,2'b00,2'b00,1'b0,2'b00,3'b000,2'b00)));
            if (funct[0] && cx) begin
                pend_flags[3:2] = aluf[3:2];
                if (ar) pend_flags[1:0] = aluf[1:0];
            end
        end
    endtask

    task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    function automatic logic [17:0] dut_word();
        return {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.ByteMem, bus.RegWrite,
                bus.RegSrc, bus.ImmSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc};
    endfunction

    // entered just after a rising edge; each record covers one clock cycle
    task automatic run(input string name, input int n);
        int lim;
        lim = (n < q.size()) ? n : q.size();
        for (int i = 0; i < lim; i++) begin
            bus.MemReady = q[i].mr;
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, i), dut_word(), q[i].cw);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic instr(input string name, input logic [3:0] cond, input logic [1:0] op,
                         input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluf,
                         input int fstall, input int mstall, input int exp_len);
        bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.ALUFlags = aluf;
        build(cond, op, funct, rd, aluf, fstall, mstall);
        if (exp_len >= 0)
            check({name, " len"}, 18'(q.size()), 18'(exp_len));
        run(name, q.size());
        mflags = pend_flags;
        check({name, " flags"}, {14'd0, dut.u_cond.flags}, {14'd0, mflags});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0;
        bus.ALUFlags = 4'd0; bus.MemReady = 1'b1;
        mflags = 4'b0000;
        reset = 1'b1;
        #2;
        check("reset writes", {14'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 18'd0);
        @(posedge clk); #1;
        check("reset held writes", {14'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 18'd0);
        check("reset flags", {14'd0, dut.u_cond.flags}, 18'd0);
        reset = 1'b0;

        instr("addi", 4'b1110, 2'b00, 6'b101000, 4'd1, 4'b0000, 0, 0, 4);
        instr("ldrb", 4'b1110, 2'b01, 6'b011101, 4'd2, 4'b0000, 0, 3, 8);
        instr("subs_z", 4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100, 0, 0, 4);
        check("subs_z literal flags", {14'd0, dut.u_cond.flags}, {14'd0, 4'b0100});
        bus.Cond = 4'b0000; bus.Op = 2'b10;
        build(4'b0000, 2'b10, 6'b101000, 4'd0, 4'b0000, 0, 0);
        check("beq taken model pcw", {17'd0, q[2].cw[17]}, 18'd1);
        instr("beq_t", 4'b0000, 2'b10, 6'b101000, 4'd0, 4'b0000, 0, 0, 3);
        instr("subs_nz", 4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0000, 0, 0, 4);
        instr("beq_nt", 4'b0000, 2'b10, 6'b101000, 4'd0, 4'b0000, 0, 0, 3);
        instr("cmp", 4'b1110, 2'b00, 6'b010101, 4'd0, 4'b1000, 0, 0, 4);
        check("cmp literal flags", {14'd0, dut.u_cond.flags}, {14'd0, 4'b1000});
        instr("subs_z2", 4'b1110, 2'b00, 6'b000101, 4'd3, 4'b0100, 0, 0, 4);
        instr("strne", 4'b0001, 2'b01, 6'b011000, 4'd4, 4'b0000, 0, 2, 6);
        instr("strb", 4'b1110, 2'b01, 6'b011100, 4'd4, 4'b0000, 1, 2, 7);
        instr("ldr_pc", 4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000, 0, 0, 5);
        instr("adds", 4'b1110, 2'b00, 6'b101001, 4'd5, 4'b1111, 0, 0, 4);
        instr("ands", 4'b1110, 2'b00, 6'b000001, 4'd5, 4'b0100, 0, 0, 4);
        check("ands literal flags", {14'd0, dut.u_cond.flags}, {14'd0, 4'b0111});
        instr("mov_pc", 4'b1110, 2'b00, 6'b011010, 4'd15, 4'b0000, 0, 0, 4);
        instr("bad_alu", 4'b1110, 2'b00, 6'b001110, 4'd6, 4'b0000, 0, 0, 4);
        instr("nv_add", 4'b1111, 2'b00, 6'b101000, 4'd1, 4'b0000, 0, 0, 4);
        instr("bhi", 4'b1000, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, 3);
        instr("bge", 4'b1010, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, 3);
        instr("bls", 4'b1001, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0, 3);
        instr("op11", 4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000, 2, 0, 4);

        // abandon a store mid-stall with reset
        bus.Cond = 4'b1110; bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'd7;
        build(4'b1110, 2'b01, 6'b011000, 4'd7, 4'b0000, 0, 5);
        run("str_rst", 4);
        bus.MemReady = 1'b1;
        #1;
        check("memwr commit strobe", {17'd0, bus.MemWrite}, 18'd1);
        reset = 1'b1;
        #1;
        check("rst mid memwr writes", {14'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}, 18'd0);
        check("rst mid memwr flags", {14'd0, dut.u_cond.flags}, 18'd0);
        mflags = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b0;
        instr("add_after_rst", 4'b1110, 2'b00, 6'b101000, 4'd1, 4'b0000, 2, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
